// File: rtl/wb_rec_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wb_rec_pkg : shared types and helpers for the WB txn recorder    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package wb_rec_pkg;

  localparam int REC_ADDR_W = 2;
  localparam int REC_DATA_W = 8;
  localparam int REC_DEPTH  = 16;
  localparam int REC_TS_W   = 16;

  // Record layout at default widths; the top rebuilds it at its own widths.
  typedef struct packed {
    logic                  we;
    logic [REC_ADDR_W-1:0] adr;
    logic [REC_DATA_W-1:0] dat;
    logic [REC_TS_W-1:0]   ts;
  } wb_rec_t;

  typedef enum logic [1:0] {
    REC_IDLE  = 2'd0,
    REC_ARMED = 2'd1,
    REC_RUN   = 2'd2
  } rec_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_rec_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wb_rec_fifo : circular record buffer with first-word-fall-through|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module wb_rec_fifo #(
  parameter int DEPTH = 16,
  parameter int REC_W = 27
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [REC_W-1:0]       wdata_i,
  output logic [REC_W-1:0]       head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [REC_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic [PTR_W:0]   count_d;

  // Push and pop together (including overwrite-when-full) leave count unchanged.
  always_comb begin
    count_d = count_q + {{PTR_W{1'b0}}, push_i} - {{PTR_W{1'b0}}, pop_i};
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/wb_txn_recorder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wb_txn_recorder : timestamps snooped Wishbone cycles into a FIFO |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module wb_txn_recorder
  import wb_rec_pkg::*;
#(
  parameter int ADDR_W    = REC_ADDR_W,
  parameter int DATA_W    = REC_DATA_W,
  parameter int DEPTH     = REC_DEPTH,
  parameter int TS_W      = REC_TS_W,
  parameter int OVERWRITE = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wb_cyc_i,
  input  logic                   wb_stb_i,
  input  logic                   wb_we_i,
  input  logic [ADDR_W-1:0]      wb_adr_i,
  input  logic [DATA_W-1:0]      wb_dat_m_i,
  input  logic [DATA_W-1:0]      wb_dat_s_i,
  input  logic                   wb_ack_i,
  input  logic                   en_i,
  input  logic                   trig_en_i,
  input  logic [ADDR_W-1:0]      trig_adr_i,
  input  logic                   clr_i,
  output logic                   rec_valid_o,
  input  logic                   rec_ready_i,
  output logic                   rec_we_o,
  output logic [ADDR_W-1:0]      rec_adr_o,
  output logic [DATA_W-1:0]      rec_dat_o,
  output logic [TS_W-1:0]        rec_ts_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   overflow_o,
  output logic [7:0]             drop_cnt_o
);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] dat;
    logic [TS_W-1:0]   ts;
  } rec_t;

  localparam int REC_W = $bits(rec_t);
  localparam bit OW_EN = (OVERWRITE != 0);

  rec_state_e            state_q;
  logic [TS_W-1:0]       ts_q;
  logic                  overflow_q;
  logic [7:0]            drop_cnt_q;

  logic                  bus_ack;
  logic                  trig_hit;
  logic                  capture;
  logic                  pop;
  logic                  full;
  logic                  drop;
  logic                  push;
  logic                  fifo_pop;
  logic                  flush;
  rec_t                  new_rec;
  rec_t                  head;
  logic [$clog2(DEPTH):0] count;

  assign bus_ack  = wb_cyc_i & wb_stb_i & wb_ack_i;
  assign trig_hit = bus_ack & wb_we_i & (wb_adr_i == trig_adr_i);
  assign capture  = ((state_q == REC_RUN) & bus_ack) | ((state_q == REC_ARMED) & trig_hit);

  assign pop   = rec_ready_i & rec_valid_o;
  assign full  = (count == ($clog2(DEPTH)+1)'(DEPTH));
  // A pop in the same cycle frees a slot, so a full buffer only loses data without one.
  assign drop     = capture & full & ~pop;
  assign push     = capture & (~drop | OW_EN);
  assign fifo_pop = pop | (drop & OW_EN);
  assign flush    = rst_i | clr_i;

  assign new_rec.we  = wb_we_i;
  assign new_rec.adr = wb_adr_i;
  assign new_rec.dat = wb_we_i ? wb_dat_m_i : wb_dat_s_i;
  assign new_rec.ts  = ts_q;

  wb_rec_fifo #(
    .DEPTH (DEPTH),
    .REC_W (REC_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (flush),
    .push_i  (push),
    .pop_i   (fifo_pop),
    .wdata_i (new_rec),
    .head_o  (head),
    .count_o (count)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= REC_IDLE;
      ts_q       <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (clr_i) begin
      state_q    <= trig_en_i ? REC_ARMED : REC_RUN;
      ts_q       <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
      if (drop) begin
        overflow_q <= 1'b1;
        drop_cnt_q <= sat_inc8(drop_cnt_q);
      end
      if (!en_i) begin
        state_q <= REC_IDLE;
      end else begin
        case (state_q)
          REC_IDLE:  state_q <= trig_en_i ? REC_ARMED : REC_RUN;
          REC_ARMED: if (trig_hit) state_q <= REC_RUN;
          default:   state_q <= state_q;
        endcase
      end
    end
  end

  // Head fields read as zero while the buffer is empty.
  assign rec_valid_o = (count != '0);
  assign rec_we_o    = rec_valid_o & head.we;
  assign rec_adr_o   = head.adr & {ADDR_W{rec_valid_o}};
  assign rec_dat_o   = head.dat & {DATA_W{rec_valid_o}};
  assign rec_ts_o    = head.ts & {TS_W{rec_valid_o}};
  assign count_o     = count;
  assign overflow_o  = overflow_q;
  assign drop_cnt_o  = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_txn_recorder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_wb_txn_recorder : three recorder variants against a queue model|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_wb_txn_recorder;

  typedef struct packed {
    logic       we;
    logic [1:0] adr;
    logic [7:0] dat;
    logic [15:0] ts;
  } mrec_t;

  localparam int S_IDLE = 0, S_ARMED = 1, S_RUN = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, clr = 1'b0, cyc = 1'b0, stb = 1'b0, we = 1'b0, ack = 1'b0;
  logic en = 1'b0, trig_en = 1'b0, rdy = 1'b0;
  logic [1:0] adr = '0, trig_adr = '0;
  logic [7:0] dm = '0, ds = '0;

  logic       o_vld [3];
  logic       o_we  [3];
  logic [1:0] o_adr [3];
  logic [7:0] o_dat [3];
  logic       o_ovf [3];
  logic [7:0] o_drop[3];
  logic [15:0] ts0, ts2;
  logic [3:0]  ts1;
  logic [4:0]  c0;
  logic [2:0]  c1, c2;

  // Instance 0: default sizes; 1: DEPTH 4, TS_W 4, drop newest; 2: DEPTH 4, discard oldest.
  wb_txn_recorder #(.ADDR_W(2), .DATA_W(8), .DEPTH(16), .TS_W(16), .OVERWRITE(0)) u0 (
    .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
    .wb_dat_m_i(dm), .wb_dat_s_i(ds), .wb_ack_i(ack), .en_i(en), .trig_en_i(trig_en),
    .trig_adr_i(trig_adr), .clr_i(clr), .rec_valid_o(o_vld[0]), .rec_ready_i(rdy),
    .rec_we_o(o_we[0]), .rec_adr_o(o_adr[0]), .rec_dat_o(o_dat[0]), .rec_ts_o(ts0),
    .count_o(c0), .overflow_o(o_ovf[0]), .drop_cnt_o(o_drop[0]));

  wb_txn_recorder #(.ADDR_W(2), .DATA_W(8), .DEPTH(4), .TS_W(4), .OVERWRITE(0)) u1 (
    .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
    .wb_dat_m_i(dm), .wb_dat_s_i(ds), .wb_ack_i(ack), .en_i(en), .trig_en_i(trig_en),
    .trig_adr_i(trig_adr), .clr_i(clr), .rec_valid_o(o_vld[1]), .rec_ready_i(rdy),
    .rec_we_o(o_we[1]), .rec_adr_o(o_adr[1]), .rec_dat_o(o_dat[1]), .rec_ts_o(ts1),
    .count_o(c1), .overflow_o(o_ovf[1]), .drop_cnt_o(o_drop[1]));

  wb_txn_recorder #(.ADDR_W(2), .DATA_W(8), .DEPTH(4), .TS_W(16), .OVERWRITE(1)) u2 (
    .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
    .wb_dat_m_i(dm), .wb_dat_s_i(ds), .wb_ack_i(ack), .en_i(en), .trig_en_i(trig_en),
    .trig_adr_i(trig_adr), .clr_i(clr), .rec_valid_o(o_vld[2]), .rec_ready_i(rdy),
    .rec_we_o(o_we[2]), .rec_adr_o(o_adr[2]), .rec_dat_o(o_dat[2]), .rec_ts_o(ts2),
    .count_o(c2), .overflow_o(o_ovf[2]), .drop_cnt_o(o_drop[2]));

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: a bounded queue per instance plus the recorder's control rules.
  int    dep [3] = '{16, 4, 4};
  int    tsm [3] = '{65536, 16, 65536};
  bit    owm [3] = '{1'b0, 1'b0, 1'b1};
  mrec_t mq  [3][$];
  int    mstate[3];
  int    mts [3];
  bit    movf[3];
  int    mdrop[3];
  bit    mdl_live = 1'b0;

  task automatic model_step(input int k);
    bit bus, trig, cap, pop;
    mrec_t r;
    if (rst || clr) begin
      mq[k].delete();
      mts[k]   = 0;
      movf[k]  = 1'b0;
      mdrop[k] = 0;
      if (rst) mstate[k] = S_IDLE;
      else     mstate[k] = trig_en ? S_ARMED : S_RUN;
    end else begin
      bus  = cyc && stb && ack;
      trig = bus && we && (adr == trig_adr);
      cap  = (mstate[k] == S_RUN && bus) || (mstate[k] == S_ARMED && trig);
      pop  = rdy && (mq[k].size() > 0);
      r.we  = we;
      r.adr = adr;
      r.dat = we ? dm : ds;
      r.ts  = 16'(mts[k]);
      if (pop) void'(mq[k].pop_front());
      if (cap) begin
        if (mq[k].size() < dep[k]) begin
          mq[k].push_back(r);
        end else begin
          movf[k] = 1'b1;
          if (mdrop[k] < 255) mdrop[k] = mdrop[k] + 1;
          if (owm[k]) begin
            void'(mq[k].pop_front());
            mq[k].push_back(r);
          end
        end
      end
      mts[k] = (mts[k] + 1) % tsm[k];
      if (!en) mstate[k] = S_IDLE;
      else if (mstate[k] == S_IDLE) mstate[k] = trig_en ? S_ARMED : S_RUN;
      else if (mstate[k] == S_ARMED && trig) mstate[k] = S_RUN;
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) model_step(k);
    if (rst) mdl_live = 1'b1;
  end

  function automatic logic [31:0] get_cnt(input int k);
    case (k)
      0:       return 32'(c0);
      1:       return 32'(c1);
      default: return 32'(c2);
    endcase
  endfunction

  function automatic logic [31:0] get_ts(input int k);
    case (k)
      0:       return 32'(ts0);
      1:       return 32'(ts1);
      default: return 32'(ts2);
    endcase
  endfunction

  task automatic cmp(input int k, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL u%0d %s @%0t: got %0h expected %0h", k, name, $time, act, exp);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  mrec_t cmp_h;
  always @(negedge clk) begin
    if (mdl_live) begin
      for (int k = 0; k < 3; k++) begin
        cmp_h = (mq[k].size() > 0) ? mq[k][0] : '0;
        cmp(k, "valid", 32'(o_vld[k]), 32'(mq[k].size() > 0));
        cmp(k, "count", get_cnt(k), 32'(mq[k].size()));
        cmp(k, "rec_we", 32'(o_we[k]), 32'(cmp_h.we));
        cmp(k, "rec_adr", 32'(o_adr[k]), 32'(cmp_h.adr));
        cmp(k, "rec_dat", 32'(o_dat[k]), 32'(cmp_h.dat));
        cmp(k, "rec_ts", get_ts(k), 32'(cmp_h.ts));
        cmp(k, "overflow", 32'(o_ovf[k]), 32'(movf[k]));
        cmp(k, "drop_cnt", 32'(o_drop[k]), 32'(mdrop[k]));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic xfer(input logic w, input logic [1:0] a, input logic [7:0] d, input logic r);
    cyc = 1'b1; stb = 1'b1; ack = 1'b1; we = w; adr = a; dm = d; ds = ~d; rdy = r;
    tick();
    cyc = 1'b0; stb = 1'b0; ack = 1'b0; rdy = 1'b0;
  endtask

  task automatic do_pop();
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  logic [7:0] a_dat [3] = '{8'hA1, 8'hA2, 8'hA3};

  initial begin
    tick();
    tick();
    chk("reset count", 32'(c0), 32'd0);
    chk("reset valid", 32'(o_vld[0]), 32'd0);
    chk("reset drop", 32'(o_drop[1]), 32'd0);
    rst = 1'b0; en = 1'b1;
    tick();

    // Three writes, then drain in order with rising timestamps.
    for (int i = 0; i < 3; i++) xfer(1'b1, 2'(i), a_dat[i], 1'b0);
    chk("3w count", 32'(c0), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("3w dat", 32'(o_dat[0]), 32'(a_dat[i]));
      chk("3w adr", 32'(o_adr[0]), 32'(i));
      chk("3w ts", 32'(ts0), 32'(i + 1));
      do_pop();
    end
    chk("3w drained", 32'(o_vld[0]), 32'd0);

    // Six writes into depth-4 buffers: drop-newest keeps 1..4, discard-oldest keeps 3..6.
    do_clr();
    for (int i = 1; i <= 6; i++) xfer(1'b1, 2'(i % 4), 8'(8'h10 + i), 1'b0);
    chk("ow0 count", 32'(c1), 32'd4);
    chk("ow0 drop", 32'(o_drop[1]), 32'd2);
    chk("ow0 ovf", 32'(o_ovf[1]), 32'd1);
    chk("ow1 count", 32'(c2), 32'd4);
    chk("ow1 drop", 32'(o_drop[2]), 32'd2);
    chk("d16 count", 32'(c0), 32'd6);
    chk("d16 drop", 32'(o_drop[0]), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("ow0 order", 32'(o_dat[1]), 32'(8'h11 + i));
      chk("ow1 order", 32'(o_dat[2]), 32'(8'h13 + i));
      do_pop();
    end

    // Full buffer with simultaneous pop and capture: nothing lost.
    do_clr();
    for (int i = 1; i <= 4; i++) xfer(1'b1, 2'd0, 8'(8'h20 + i), 1'b0);
    xfer(1'b1, 2'd1, 8'h25, 1'b1);
    chk("fullpop count", 32'(c2), 32'd4);
    chk("fullpop drop", 32'(o_drop[2]), 32'd0);
    chk("fullpop ovf", 32'(o_ovf[2]), 32'd0);
    chk("fullpop head", 32'(o_dat[2]), 32'h22);
    chk("fullpop ow0 drop", 32'(o_drop[1]), 32'd0);

    // Trigger on write to address 2.
    trig_en = 1'b1; trig_adr = 2'd2;
    do_clr();
    xfer(1'b1, 2'd1, 8'h31, 1'b0);
    xfer(1'b0, 2'd2, 8'h32, 1'b0);
    xfer(1'b1, 2'd2, 8'h33, 1'b0);
    xfer(1'b1, 2'd3, 8'h34, 1'b0);
    chk("trig count", 32'(c0), 32'd2);
    chk("trig adr0", 32'(o_adr[0]), 32'd2);
    chk("trig we0", 32'(o_we[0]), 32'd1);
    chk("trig dat0", 32'(o_dat[0]), 32'h33);
    do_pop();
    chk("trig adr1", 32'(o_adr[0]), 32'd3);
    chk("trig dat1", 32'(o_dat[0]), 32'h34);
    do_pop();
    trig_en = 1'b0;

    // Timestamp wrap: events at ts 4, 24, 44 (mod 16 -> 4, 8, 12).
    do_clr();
    repeat (4) tick();
    xfer(1'b1, 2'd0, 8'h41, 1'b0);
    repeat (19) tick();
    xfer(1'b1, 2'd1, 8'h42, 1'b0);
    repeat (19) tick();
    xfer(1'b1, 2'd2, 8'h43, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("ts16", 32'(ts0), 32'(4 + 20 * i));
      chk("ts4 wrap", 32'(ts1), 32'((4 + 20 * i) % 16));
      do_pop();
    end

    // Drop counter saturation.
    do_clr();
    for (int i = 0; i < 304; i++) xfer(1'b1, 2'(i % 4), 8'(i), 1'b0);
    chk("sat drop u1", 32'(o_drop[1]), 32'd255);
    chk("sat drop u2", 32'(o_drop[2]), 32'd255);
    chk("sat drop u0", 32'(o_drop[0]), 32'd255);
    chk("sat count u0", 32'(c0), 32'd16);

    // clr and rst mid-burst override the capture of that cycle.
    do_clr();
    chk("clr drop", 32'(o_drop[1]), 32'd0);
    chk("clr ovf", 32'(o_ovf[1]), 32'd0);
    for (int i = 0; i < 3; i++) xfer(1'b1, 2'd1, 8'(8'h50 + i), 1'b0);
    clr = 1'b1;
    xfer(1'b1, 2'd1, 8'h5F, 1'b0);
    clr = 1'b0;
    chk("clr burst count", 32'(c0), 32'd0);
    chk("clr burst valid", 32'(o_vld[0]), 32'd0);
    for (int i = 0; i < 3; i++) xfer(1'b1, 2'd2, 8'(8'h60 + i), 1'b0);
    rst = 1'b1;
    xfer(1'b1, 2'd2, 8'h6F, 1'b0);
    rst = 1'b0;
    chk("rst burst count", 32'(c0), 32'd0);
    chk("rst burst dat", 32'(o_dat[0]), 32'd0);
    tick();

    // Back-to-back ACKs with the consumer popping every cycle.
    do_clr();
    for (int i = 0; i < 40; i++) xfer(1'b1, 2'(i % 4), 8'(8'h80 + i), 1'b1);
    chk("b2b count", 32'(c1), 32'd1);
    chk("b2b drop", 32'(o_drop[1]), 32'd0);
    chk("b2b last", 32'(o_dat[1]), 32'h80 + 32'd39);

    // Disabled recorder ignores traffic but keeps contents.
    en = 1'b0;
    tick();
    xfer(1'b1, 2'd3, 8'hEE, 1'b0);
    chk("idle keep", 32'(c0), 32'd1);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
